twos_to_signmag_serial: RTL and testbench
=========================================

Name: twos_to_signmag_serial

Overview:
- Bit-serial decoder that takes a W-bit two's-complement word and returns it as sign plus unsigned magnitude.
- It is the inverse companion of the team's combinational two's-complement negator.
- Magnitude is produced LSB-first with the copy-until-first-one, then-invert rule, one bit per clock.
- Sits between signed datapath results and sign-magnitude consumers (display / BCD path); valid/ready on both sides.

Parameters:
- W, 4, word width in bits (W >= 2).
- CW, $clog2(W), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block can accept a word.
- in_data  input  W  two's-complement operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sign  output  1  sign of operand (1 = negative).
- out_mag  output  W  unsigned magnitude |in_data|.
- out_min  output  1  operand was the most-negative value (1 followed by W-1 zeros).

Behaviour:
- Reset is asynchronous on rst_n low. All of the following hold while reset is asserted and on release:
  - state = IDLE.
  - in_ready = 1.
  - out_valid, out_sign, out_min = 0.
  - out_mag = 0.
  - Internal shift register, counter and seen_one = 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at a rising edge:
    - Latch sr = in_data and sign = in_data[W-1].
    - Clear seen_one, cnt and mag.
    - Set min = (in_data == {1'b1, {W-1{1'b0}}}).
    - Go to CONV.
- CONV:
  - in_ready = 0; in_valid is ignored.
  - Each cycle, with b = sr[0]:
    - res = sign ? (seen_one ? ~b : b) : b.
    - seen_one <= seen_one | b.
    - sr >>= 1.
    - mag <= {res, mag[W-1:1]}.
    - cnt++.
  - When cnt == W-1, go to DONE on that edge.
  - CONV always takes exactly W cycles, whatever the sign, so latency is deterministic.
- DONE:
  - out_valid = 1 and out_sign / out_mag / out_min are stable.
  - Outputs hold unchanged while out_ready = 0; there is no timeout.
  - On out_ready, go to IDLE next edge; out_valid drops.
- Latency: out_valid rises on the W-th rising edge after the accept edge.
- Throughput: one word per W+2 cycles at best. in_ready is not asserted in DONE; no bypass of DONE.
- Width rules:
  - out_mag is W-bit unsigned, so the most-negative value yields mag = 2^(W-1) exactly (W=4: 1000 -> mag 1000) with out_min = 1. No saturation.
  - Zero gives sign = 0, mag = 0.
- Outputs are registered; no combinational path from in_* to out_*.
- in_ready is decoded from state only (not from in_valid).
- Reset mid-operation: the operation is aborted; no partial result appears after reset release.
- out_sign/out_mag/out_min keep the last result after the DONE -> IDLE transition. Consumers must qualify them with out_valid.

Decomposition:
- Shared package (signmag_pkg):
  - state enum {IDLE, CONV, DONE}.
  - Localparam helper for CW.
  - Function for the most-negative constant of width W.
- One natural sub-module: serial_negate_bit. It holds the per-bit cell: inputs b, sign, seen_one, clk/rst_n, plus a clear from the accept strobe; outputs res and registered seen_one.
- The top instantiates serial_negate_bit and owns the FSM, counter and shift registers.

Test Plan:
- Reset: rst_n low for 3 cycles -> in_ready = 1, out_valid = 0, out_mag = 0000, out_sign = 0, out_min = 0.
- Positive, W=4: accept 0101 -> out_valid on the 4th edge after accept; out_sign = 0, out_mag = 0101, out_min = 0.
- Negatives:
  - Accept 1011 (-5) -> out_sign = 1, out_mag = 0101.
  - Accept 1111 -> out_sign = 1, out_mag = 0001.
- Most-negative and zero:
  - Accept 1000 -> out_sign = 1, out_mag = 1000, out_min = 1.
  - Accept 0000 -> out_sign = 0, out_mag = 0000.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 6 cycles in DONE -> outputs stable, in_ready = 0.
  - Toggle in_valid with 0111 during CONV -> ignored; the first result is unchanged.
- Reset mid-CONV: assert rst_n low 2 cycles after accepting 1010 -> immediate return to reset values; after release, the next accepted 0011 gives mag 0011 with no residue.

Source files
------------

// File: rtl/signmag_pkg.sv
// rtl/signmag_pkg.sv - shared types and helpers for the serial sign-magnitude decoder
package signmag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Most-negative two's-complement value of width w, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] most_neg(input int w);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/serial_negate_bit.sv
// rtl/serial_negate_bit.sv - per-bit copy-until-first-one-then-invert cell
module serial_negate_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_b,
  input  logic i_sign,
  input  logic i_seen_one,
  output logic o_res,
  output logic o_seen_one
);

  logic r_seen_one;

  // Negative operands invert every bit above the lowest set bit.
  always_comb begin
    o_res = i_b;
    if (i_sign && i_seen_one) begin
      o_res = ~i_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_one <= 1'b0;
    end else if (i_clear) begin
      r_seen_one <= 1'b0;
    end else if (i_en) begin
      r_seen_one <= i_seen_one | i_b;
    end
  end

  assign o_seen_one = r_seen_one;

endmodule

// File: rtl/twos_to_signmag_serial.sv
// rtl/twos_to_signmag_serial.sv - bit-serial two's-complement to sign-magnitude decoder
module twos_to_signmag_serial
  import signmag_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         out_min
);

  localparam int CW = cnt_width(W);
  localparam logic [W-1:0] MIN_VAL = W'(most_neg(W));

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_sr;
  logic [W-1:0]    r_mag;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_min;
  logic            w_accept;
  logic            w_conv;
  logic            w_last;
  logic            w_res;
  logic            w_seen_one;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_conv    = (r_state == CONV);
  assign w_last    = w_conv && (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = CONV;
      CONV: if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Magnitude bits enter at the MSB so the LSB-first stream lands in place after W shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_mag  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_min  <= 1'b0;
    end else if (w_accept) begin
      r_sr   <= in_data;
      r_mag  <= '0;
      r_cnt  <= '0;
      r_sign <= in_data[W-1];
      r_min  <= (in_data == MIN_VAL);
    end else if (w_conv) begin
      r_sr  <= r_sr >> 1;
      r_mag <= {w_res, r_mag[W-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  serial_negate_bit u_negate_bit (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept),
    .i_en       (w_conv),
    .i_b        (r_sr[0]),
    .i_sign     (r_sign),
    .i_seen_one (w_seen_one),
    .o_res      (w_res),
    .o_seen_one (w_seen_one)
  );

  assign out_sign = r_sign;
  assign out_mag  = r_mag;
  assign out_min  = r_min;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb/tb_twos_to_signmag_serial.sv - self-checking bench for twos_to_signmag_serial
module tb_twos_to_signmag_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_min;

  int n_checks;
  int n_errors;

  twos_to_signmag_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_min   (out_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the word as a signed integer and take its absolute value.
  task automatic model(input logic [W-1:0] x, output logic sign, output logic [W-1:0] mag,
                       output logic min);
    int v;
    v = int'(x);
    if (x[W-1]) v = v - (1 << W);
    sign = (v < 0);
    mag  = W'((v < 0) ? -v : v);
    min  = (v == -(1 << (W - 1)));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_mag"}, 32'(out_mag), 32'd0);
    check({tag, "_out_sign"}, 32'(out_sign), 32'd0);
    check({tag, "_out_min"}, 32'(out_min), 32'd0);
  endtask

  // Accept one word, wait for the result, hold it under backpressure, then retire it.
  task automatic run_word(input logic [W-1:0] d, input int hold, input bit toggle_in);
    logic         e_sign;
    logic [W-1:0] e_mag;
    logic         e_min;
    int           lat;
    model(d, e_sign, e_mag, e_min);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (toggle_in && !out_valid) begin
        in_valid = ~in_valid;
        in_data  = W'(7);
      end
    end
    in_valid = 1'b0;
    check($sformatf("latency_%0h", d), 32'(lat), 32'(W));
    check($sformatf("sign_%0h", d), 32'(out_sign), 32'(e_sign));
    check($sformatf("mag_%0h", d), 32'(out_mag), 32'(e_mag));
    check($sformatf("min_%0h", d), 32'(out_min), 32'(e_min));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_mag", 32'(out_mag), 32'(e_mag));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire_valid", 32'(out_valid), 32'd0);
    check("retire_in_ready", 32'(in_ready), 32'd1);
    check("retire_mag_kept", 32'(out_mag), 32'(e_mag));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    run_word(4'b0101, 0, 1'b0);
    run_word(4'b1011, 0, 1'b0);
    run_word(4'b1111, 0, 1'b0);
    run_word(4'b1000, 0, 1'b0);
    run_word(4'b0000, 0, 1'b0);
    run_word(4'b1101, 6, 1'b0);
    run_word(4'b1001, 0, 1'b1);

    // Abort a conversion two cycles after it was accepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("mid_release");
    run_word(4'b0011, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_word(W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
